// File: rtl/inst_sram_slave.sv
// SRAM-like bus responder: accepts requests, drives a 1-cycle RAM,
// and returns in-order responses with configurable wait states.
module inst_sram_slave #(
    parameter int QDEPTH_LOG2 = 2,
    parameter int ADDR_DELAY  = 0,
    parameter int DATA_DELAY  = 1,
    parameter int RAM_AW      = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int         QW    = QDEPTH_LOG2;
    localparam int         DEPTH = 1 << QW;
    localparam logic [3:0] DD    = 4'(DATA_DELAY);
    localparam logic [QW:0] FULL = (QW+1)'(DEPTH);

    logic [QW-1:0] wptr_q, wptr_d;
    logic [QW-1:0] rptr_q, rptr_d;
    logic [QW:0]   cnt_q, cnt_d;
    logic          rd_pend_q, rd_pend_d;
    logic [QW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] e_vld_q, e_vld_d;
    logic [31:0]   e_data_q [DEPTH];
    logic [31:0]   e_data_d [DEPTH];
    logic [3:0]    e_age_q  [DEPTH];
    logic [3:0]    e_age_d  [DEPTH];
    logic [QW-1:0] off      [DEPTH];
    logic [DEPTH-1:0] live;
    logic          wait_ok;
    logic          head_rdy;
    logic          unused_ok;

    assign unused_ok = ^{size, addr[1:0], addr[31:RAM_AW+2]};

    // Wait counter only exists when an address-phase delay is requested.
    generate
        if (ADDR_DELAY == 0) begin : g_nowait
            assign wait_ok = 1'b1;
        end else begin : g_wait
            localparam logic [7:0] AD = 8'(ADDR_DELAY);
            logic [7:0] wait_q, wait_d;

            always_comb begin
                wait_d = wait_q;
                if (!req || addr_ok) begin
                    wait_d = '0;
                end else if (wait_q < AD) begin
                    wait_d = wait_q + 8'd1;
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    wait_q <= '0;
                end else begin
                    wait_q <= wait_d;
                end
            end

            assign wait_ok = (wait_q >= AD);
        end
    endgenerate

    assign addr_ok = resetn && req && (cnt_q < FULL) && wait_ok;

    // An entry without captured data can only be last cycle's read.
    assign head_rdy = e_vld_q[rptr_q] || (rd_pend_q && (rd_ptr_q == rptr_q));
    assign data_ok  = resetn && (cnt_q != '0) && (e_age_q[rptr_q] >= DD) && head_rdy;
    assign rdata    = !data_ok ? 32'h0 :
                      e_vld_q[rptr_q] ? e_data_q[rptr_q] : ram_rdata;

    assign ram_en    = addr_ok;
    assign ram_we    = (addr_ok && wr) ? wstrb : 4'b0000;
    assign ram_addr  = addr[RAM_AW+1:2];
    assign ram_wdata = wdata;

    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off[i]  = QW'(i) - rptr_q;
            live[i] = ({1'b0, off[i]} < cnt_q);
        end
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        rd_pend_d = addr_ok && !wr;
        rd_ptr_d  = wptr_q;
        e_vld_d   = e_vld_q;
        e_data_d  = e_data_q;
        e_age_d   = e_age_q;

        if (rd_pend_q) begin
            e_data_d[rd_ptr_q] = ram_rdata;
            e_vld_d[rd_ptr_q]  = 1'b1;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (e_age_q[i] < DD)) begin
                e_age_d[i] = e_age_q[i] + 4'd1;
            end
        end

        // Age starts at 1 so DATA_DELAY=1 answers the cycle after accept.
        if (addr_ok) begin
            e_data_d[wptr_q] = 32'h0;
            e_vld_d[wptr_q]  = wr;
            e_age_d[wptr_q]  = 4'd1;
            wptr_d           = wptr_q + 1'b1;
        end

        if (data_ok) begin
            rptr_d = rptr_q + 1'b1;
        end

        if (addr_ok && !data_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!addr_ok && data_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_ptr_q  <= '0;
            e_vld_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_data_q[i] <= '0;
                e_age_q[i]  <= '0;
            end
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_ptr_q  <= rd_ptr_d;
            e_vld_q   <= e_vld_d;
            e_data_q  <= e_data_d;
            e_age_q   <= e_age_d;
        end
    end

endmodule

// File: tb/tb_inst_sram_slave.sv
// Directed bench for inst_sram_slave: four instances with different
// delay settings, each backed by its own behavioural RAM.
module tb_inst_sram_slave;

    typedef struct {
        logic        req;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        load;

    logic        aok [4];
    logic        dok [4];
    logic [31:0] rd  [4];
    logic        ren [4];
    logic [3:0]  rwe [4];
    logic [15:0] ra  [4];
    logic [31:0] rwd [4];
    logic [31:0] rr  [4];
    logic [31:0] mem [4][256];

    int tests;
    int fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    inst_sram_slave u0 (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd[0]),
        .ram_en(ren[0]), .ram_we(rwe[0]), .ram_addr(ra[0]),
        .ram_wdata(rwd[0]), .ram_rdata(rr[0])
    );

    inst_sram_slave #(.DATA_DELAY(8)) u1 (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd[1]),
        .ram_en(ren[1]), .ram_we(rwe[1]), .ram_addr(ra[1]),
        .ram_wdata(rwd[1]), .ram_rdata(rr[1])
    );

    inst_sram_slave #(.ADDR_DELAY(2)) u2 (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(aok[2]), .data_ok(dok[2]), .rdata(rd[2]),
        .ram_en(ren[2]), .ram_we(rwe[2]), .ram_addr(ra[2]),
        .ram_wdata(rwd[2]), .ram_rdata(rr[2])
    );

    inst_sram_slave #(.DATA_DELAY(5)) u3 (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(aok[3]), .data_ok(dok[3]), .rdata(rd[3]),
        .ram_en(ren[3]), .ram_we(rwe[3]), .ram_addr(ra[3]),
        .ram_wdata(rwd[3]), .ram_rdata(rr[3])
    );

    function automatic logic [31:0] init_word(input int i);
        if (i < 16)     return 32'hC0DE_0000 | 32'(i);
        if (i == 16)    return 32'h1122_3344;
        if (i == 'h40)  return 32'h1234_5678;
        return 32'hDEAD_0000 | 32'(i);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (load) begin
                for (int i = 0; i < 256; i++) mem[k][i] <= init_word(i);
            end else if (ren[k]) begin
                if (rwe[k] == 4'b0000) rr[k] <= mem[k][ra[k][7:0]];
                for (int b = 0; b < 4; b++) begin
                    if (rwe[k][b]) mem[k][ra[k][7:0]][8*b +: 8] <= rwd[k][8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
        @(posedge clk);
        #1;
        req = r; wr = w; addr = a; wstrb = s; wdata = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0; req = 1'b0; wr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                                input logic [3:0] s, input logic [31:0] d,
                                input logic ea, input logic ed, input logic [31:0] er);
        vec_t v;
        v.req = r; v.wr = w; v.addr = a; v.wstrb = s; v.wdata = d;
        v.aok = ea; v.dok = ed; v.rdata = er;
        return v;
    endfunction

    vec_t tbl [$];

    initial begin
        int n_acc;
        int n_pop;
        int seen;
        logic exp_a;
        logic exp_d;
        logic       r2 [9];
        logic       a2 [9];

        tests = 0; fails = 0;
        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd2;
        wstrb = 4'h0; addr = '0; wdata = '0; load = 1'b1;

        // Single read, write-then-read, and 16-read stream on the default instance.
        tbl.push_back(mk(1, 0, 32'h100, 4'h0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,   4'h0, 0, 0, 1, 32'h1234_5678));
        tbl.push_back(mk(0, 0, 32'h0,   4'h0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h40,  4'b0011, 32'hAABB_CCDD, 1, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h40,  4'h0, 0, 1, 1, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,   4'h0, 0, 0, 1, 32'h1122_CCDD));
        tbl.push_back(mk(0, 0, 32'h0,   4'h0, 0, 0, 0, 32'h0));
        for (int k = 0; k < 16; k++) begin
            tbl.push_back(mk(1, 0, 32'(4*k), 4'h0, 0, 1, k > 0,
                             (k > 0) ? init_word(k-1) : 32'h0));
        end
        tbl.push_back(mk(0, 0, 32'h0, 4'h0, 0, 0, 1, init_word(15)));
        tbl.push_back(mk(0, 0, 32'h0, 4'h0, 0, 0, 0, 32'h0));

        @(posedge clk);
        #1;
        load = 1'b0;
        req = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst.aok%0d", k), 32'(aok[k]), 32'h0);
            chk($sformatf("rst.dok%0d", k), 32'(dok[k]), 32'h0);
        end
        chk("rst.rdata", rd[0], 32'h0);
        chk("rst.ram_en", 32'(ren[0]), 32'h0);
        chk("rst.ram_we", 32'(rwe[0]), 32'h0);

        do_reset();
        foreach (tbl[i]) begin
            cyc(tbl[i].req, tbl[i].wr, tbl[i].addr, tbl[i].wstrb, tbl[i].wdata);
            chk($sformatf("v%0d.aok", i), 32'(aok[0]), 32'(tbl[i].aok));
            chk($sformatf("v%0d.dok", i), 32'(dok[0]), 32'(tbl[i].dok));
            chk($sformatf("v%0d.rdata", i), rd[0], tbl[i].rdata);
        end

        // Queue full with DATA_DELAY=8: stall until the first pop frees a slot.
        do_reset();
        n_acc = 0; n_pop = 0;
        for (int c = 0; c < 14; c++) begin
            exp_a = (c <= 3) || (c >= 9 && c <= 12);
            exp_d = (c >= 8 && c <= 11);
            cyc(1, 0, 32'(4*n_acc), 4'h0, 0);
            chk($sformatf("full.c%0d.aok", c), 32'(aok[1]), 32'(exp_a));
            chk($sformatf("full.c%0d.dok", c), 32'(dok[1]), 32'(exp_d));
            if (exp_d) begin
                chk($sformatf("full.c%0d.rdata", c), rd[1], init_word(n_pop));
                n_pop++;
            end
            if (exp_a) n_acc++;
        end
        cyc(0, 0, 0, 4'h0, 0);

        // ADDR_DELAY=2: held request, then a dropped-and-restarted request.
        do_reset();
        r2 = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        a2 = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
        for (int c = 0; c < 5; c++) begin
            cyc(r2[c], 0, 32'h4, 4'h0, 0);
            chk($sformatf("ad.a.c%0d", c), 32'(aok[2]), 32'(a2[c]));
        end
        r2 = '{1, 0, 0, 1, 1, 1, 0, 0, 0};
        a2 = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
        for (int c = 0; c < 7; c++) begin
            cyc(r2[c], 0, 32'h8, 4'h0, 0);
            chk($sformatf("ad.b.c%0d", c), 32'(aok[2]), 32'(a2[c]));
        end

        // Reset with three reads outstanding (DATA_DELAY=5).
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 32'(4*k), 4'h0, 0);
            chk($sformatf("fl.acc%0d", k), 32'(aok[3]), 32'h1);
        end
        @(posedge clk);
        #1;
        req = 1'b1;
        resetn = 1'b0;
        @(negedge clk);
        chk("fl.rst.aok", 32'(aok[3]), 32'h0);
        chk("fl.rst.dok", 32'(dok[3]), 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        req = 1'b0;
        @(negedge clk);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(0, 0, 0, 4'h0, 0);
            if (dok[3]) seen++;
        end
        chk("fl.no_dok", 32'(seen), 32'h0);
        cyc(1, 0, 32'h8, 4'h0, 0);
        chk("fl.new.aok", 32'(aok[3]), 32'h1);
        for (int j = 1; j <= 5; j++) begin
            cyc(0, 0, 0, 4'h0, 0);
            chk($sformatf("fl.new.dok%0d", j), 32'(dok[3]), 32'(j == 5));
            if (j == 5) chk("fl.new.rdata", rd[3], init_word(2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
